reset_sequencer: RTL and testbench

- Consumes the single global power-on reset and produces NUM_STAGES staggered, registered reset outputs, one per downstream subsystem.
- Releases the stage resets in order, stage 0 first, with a fixed spacing between releases.
- Accepts a one-cycle soft-reset request while running. On a request it re-asserts the stages in reverse order, then repeats the release sequence.
- Sits directly downstream of the power-on reset generator. Its outputs drive the reset inputs of every other block.

---
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered power-on / soft reset sequencer
//
// Purpose: turns the global power-on reset into NUM_STAGES registered,
// staggered stage resets. Stages release in ascending order, STAGE_DELAY
// cycles apart, after HOLD_MIN cycles of all-asserted hold. A soft request
// accepted in RUN re-asserts the stages in descending order, one per cycle,
// then replays the hold/release sequence.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset from the power-on generator
//   soft_req     synchronous soft-reset request, honoured only in RUN
//   stage_rst    active-high reset per downstream subsystem (bit k -> k)
//   all_released high in RUN, when every stage reset is low
//   busy         high whenever the sequencer is not in RUN
//   soft_ack     one-cycle pulse on the edge a soft_req is accepted
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_MIN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_released,
  output logic                  busy,
  output logic                  soft_ack
);

  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int MAX_DLY = (STAGE_DELAY > HOLD_MIN) ? STAGE_DELAY : HOLD_MIN;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || STAGE_DELAY < 1 || HOLD_MIN < 1) begin : g_bad_param
    $error("reset_sequencer: NUM_STAGES, STAGE_DELAY and HOLD_MIN must be >= 1");
  end
  if ((MAX_DLY - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("reset_sequencer: CNT_W too narrow for max(STAGE_DELAY, HOLD_MIN)");
  end

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  all_rel_q, all_rel_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      stage_q   <= '1;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == STAGE_LAST) begin
          stage_d[idx_q] = 1'b0;
          cnt_d          = '0;
          if (idx_q == IDX_TOP) begin
            state_d = ST_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (soft_req) begin
          ack_d                 = 1'b1;
          stage_d[NUM_STAGES-1] = 1'b1;
          cnt_d                 = '0;
          // With one stage the top stage is also stage 0, so the
          // descending re-assert pass is already complete.
          if (NUM_STAGES == 1) begin
            state_d = ST_HOLD;
            idx_d   = '0;
          end else begin
            state_d = ST_ASSERT;
            idx_d   = IDX_TOP - 1'b1;
          end
        end
      end

      ST_ASSERT: begin
        stage_d[idx_q] = 1'b1;
        if (idx_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '1;
      end
    endcase

    // Status flags are registered from the next state so they change on
    // the same edge as the state they describe.
    all_rel_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_RUN);
  end

  assign stage_rst    = stage_q;
  assign all_released = all_rel_q;
  assign busy         = busy_q;
  assign soft_ack     = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized bench for reset_sequencer against an edge-arithmetic model
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] soft_req;
  logic [3:0] rst_a;
  logic [0:0] rst_b;
  logic [1:0] all_rel;
  logic [1:0] busy;
  logic [1:0] ack;

  int n_cmp = 0;
  int n_mis = 0;
  int e;
  int acc [2];
  int ns  [2] = '{4, 1};
  int sd  [2] = '{16, 1};
  int hm  [2] = '{4, 1};

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(4), .STAGE_DELAY(16), .HOLD_MIN(4), .CNT_W(8)
  ) u_a (
    .clk(clk), .reset(reset), .soft_req(soft_req[0]), .stage_rst(rst_a),
    .all_released(all_rel[0]), .busy(busy[0]), .soft_ack(ack[0])
  );

  reset_sequencer #(
    .NUM_STAGES(1), .STAGE_DELAY(1), .HOLD_MIN(1), .CNT_W(2)
  ) u_b (
    .clk(clk), .reset(reset), .soft_req(soft_req[1]), .stage_rst(rst_b),
    .all_released(all_rel[1]), .busy(busy[1]), .soft_ack(ack[1])
  );

  // acc[i] is the edge of the latest accepted soft request (-1 = none since
  // reset). The hold/release timeline is measured from the edge on which
  // every stage is asserted: edge 0 after reset, or acc + N - 1.
  function automatic bit asserting(int i, int t);
    return (acc[i] >= 0) && (t <= acc[i] + ns[i] - 1);
  endfunction

  function automatic int origin(int i);
    return (acc[i] >= 0) ? acc[i] + ns[i] - 1 : 0;
  endfunction

  function automatic bit in_run(int i, int t);
    return !asserting(i, t) && (t >= origin(i) + hm[i] + ns[i] * sd[i]);
  endfunction

  function automatic logic [3:0] exp_stage(int i, int t);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < ns[i]; k++) begin
      if (asserting(i, t))
        v[k] = (k >= ns[i] - 1 - (t - acc[i]));
      else
        v[k] = (t < origin(i) + hm[i] + (k + 1) * sd[i]);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.stage_rst",    32'(rst_a),      32'(exp_stage(0, e)));
    chk("a.all_released", 32'(all_rel[0]), 32'(in_run(0, e)));
    chk("a.busy",         32'(busy[0]),    32'(!in_run(0, e)));
    chk("a.soft_ack",     32'(ack[0]),     32'(acc[0] == e));
    chk("b.stage_rst",    32'(rst_b),      32'(exp_stage(1, e)));
    chk("b.all_released", 32'(all_rel[1]), 32'(in_run(1, e)));
    chk("b.busy",         32'(busy[1]),    32'(!in_run(1, e)));
    chk("b.soft_ack",     32'(ack[1]),     32'(acc[1] == e));
  endtask

  // mode 0: quiet except a pulse on A at edge 30 (inside RELEASE)
  // mode 1: sparse random requests; mode 2: requests held high
  task automatic run(input int n, input int mode);
    logic [1:0] r;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      case (mode)
        0:       r = {1'b0, 1'(e + 1 == 30)};
        1:       r = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0)};
        default: r = 2'b11;
      endcase
      soft_req = r;
      @(posedge clk);
      e++;
      for (int i = 0; i < 2; i++)
        if (r[i] && in_run(i, e - 1)) acc[i] = e;
      #1 check_all();
    end
  endtask

  task automatic model_reset();
    e   = 0;
    acc = '{-1, -1};
  endtask

  initial begin
    reset    = 1'b1;
    soft_req = 2'b00;
    model_reset();
    @(posedge clk);
    #2 check_all();
    reset = 1'b0;

    run(80, 0);
    run(600, 1);
    run(300, 2);

    // fresh sequence, then reset lands between edges 40 and 41
    #1 reset = 1'b1;
    soft_req = 2'b00;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #2 reset = 1'b0;
    run(40, 0);
    #1 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #2 reset = 1'b0;
    run(80, 0);
    run(300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
